// File: rtl/hpc3_mul_scheduler_if.sv
// Requester-side bundle of the shared HPC3 multiplier: two operand request
// channels and two result channels, one lane per requester.
interface hpc3_mul_scheduler_if #(
    parameter int WIDTH = 3
);
    logic [1:0]            rq_valid;
    logic [1:0]            rq_ready;
    logic [1:0][WIDTH-1:0] rq_a_0;
    logic [1:0][WIDTH-1:0] rq_a_1;
    logic [1:0][WIDTH-1:0] rq_b_0;
    logic [1:0][WIDTH-1:0] rq_b_1;
    logic [1:0]            rs_valid;
    logic [1:0]            rs_ready;
    logic [1:0][WIDTH-1:0] rs_c_0;
    logic [1:0][WIDTH-1:0] rs_c_1;

    modport master (
        output rq_valid, rq_a_0, rq_a_1, rq_b_0, rq_b_1, rs_ready,
        input  rq_ready, rs_valid, rs_c_0, rs_c_1
    );

    modport slave (
        input  rq_valid, rq_a_0, rq_a_1, rq_b_0, rq_b_1, rs_ready,
        output rq_ready, rs_valid, rs_c_0, rs_c_1
    );
endinterface

// File: rtl/hpc3_mul_scheduler.sv
// Round-robin scheduler sharing one d=1 HPC3 masked AND gadget between two
// requesters, with LFSR randomness and per-requester result holding.
module hpc3_mul_scheduler #(
    parameter int          WIDTH   = 3,
    parameter int          LATENCY = 1,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    hpc3_mul_scheduler_if.slave rq_bus,
    output logic [WIDTH-1:0]    g_a_0,
    output logic [WIDTH-1:0]    g_a_1,
    output logic [WIDTH-1:0]    g_b_0,
    output logic [WIDTH-1:0]    g_b_1,
    output logic                g_rand_ref,
    output logic                g_rand_mul,
    input  logic [WIDTH-1:0]    g_c_0,
    input  logic [WIDTH-1:0]    g_c_1
);

    logic [1:0]            busy_q, busy_d;
    logic                  rr_q, rr_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [LATENCY-1:0]    pipe_valid_q, pipe_valid_d;
    logic [LATENCY-1:0]    pipe_id_q, pipe_id_d;
    logic [1:0]            rs_valid_q, rs_valid_d;
    logic [1:0][WIDTH-1:0] rs_c_0_q, rs_c_0_d;
    logic [1:0][WIDTH-1:0] rs_c_1_q, rs_c_1_d;

    logic [1:0] eligible;
    logic [1:0] grant;
    logic       issue;
    logic       gid;
    logic       done;
    logic       done_id;
    logic       lfsr_fb;

    // Arbiter: rr only breaks ties; no grant while reset is asserted.
    always_comb begin
        eligible = rq_bus.rq_valid & ~busy_q;
        grant    = '0;
        if (!reset) begin
            if (&eligible) grant[rr_q] = 1'b1;
            else           grant       = eligible;
        end
        issue = |grant;
        gid   = grant[1];
    end

    // Shares are muxed per requester as a whole, zero when nothing is issued.
    always_comb begin
        g_a_0      = issue ? rq_bus.rq_a_0[gid] : '0;
        g_a_1      = issue ? rq_bus.rq_a_1[gid] : '0;
        g_b_0      = issue ? rq_bus.rq_b_0[gid] : '0;
        g_b_1      = issue ? rq_bus.rq_b_1[gid] : '0;
        g_rand_mul = lfsr_q[0];
        g_rand_ref = lfsr_q[8];
    end

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_comb begin
        lfsr_d          = issue ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;
        rr_d            = issue ? ~gid : rr_q;
        pipe_valid_d[0] = issue;
        pipe_id_d[0]    = gid;
        for (int k = 1; k < LATENCY; k++) begin
            pipe_valid_d[k] = pipe_valid_q[k-1];
            pipe_id_d[k]    = pipe_id_q[k-1];
        end
        done       = pipe_valid_q[LATENCY-1];
        done_id    = pipe_id_q[LATENCY-1];
        busy_d     = busy_q;
        rs_valid_d = rs_valid_q;
        rs_c_0_d   = rs_c_0_q;
        rs_c_1_d   = rs_c_1_q;
        for (int i = 0; i < 2; i++) begin
            if (rs_valid_q[i] && rq_bus.rs_ready[i]) begin
                rs_valid_d[i] = 1'b0;
                busy_d[i]     = 1'b0;
            end
            if (done && (done_id == 1'(i))) begin
                rs_valid_d[i] = 1'b1;
                rs_c_0_d[i]   = g_c_0;
                rs_c_1_d[i]   = g_c_1;
            end
            if (grant[i]) busy_d[i] = 1'b1;
        end
    end

    // NOTE: every flop uses <= so all state advances from the same pre-edge
    // values; the tracking pipe is reset too, which is what drops in-flight ops.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q       <= '0;
            rr_q         <= 1'b0;
            lfsr_q       <= SEED;
            pipe_valid_q <= '0;
            pipe_id_q    <= '0;
            rs_valid_q   <= '0;
            rs_c_0_q     <= '0;
            rs_c_1_q     <= '0;
        end else begin
            busy_q       <= busy_d;
            rr_q         <= rr_d;
            lfsr_q       <= lfsr_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_id_q    <= pipe_id_d;
            rs_valid_q   <= rs_valid_d;
            rs_c_0_q     <= rs_c_0_d;
            rs_c_1_q     <= rs_c_1_d;
        end
    end

    assign rq_bus.rq_ready = grant;
    assign rq_bus.rs_valid = rs_valid_q;
    assign rq_bus.rs_c_0   = rs_c_0_q;
    assign rq_bus.rs_c_1   = rs_c_1_q;

endmodule

// File: tb/tb_hpc3_mul_scheduler.sv
// Randomized bench for hpc3_mul_scheduler: a behavioural gadget, a stimulus
// process that queues expected products, and a negedge monitor with a model.
module tb_hpc3_mul_scheduler;

    localparam int          WIDTH   = 3;
    localparam int          LATENCY = 1;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hpc3_mul_scheduler_if #(.WIDTH(WIDTH)) bus ();

    logic [WIDTH-1:0] g_a_0, g_a_1, g_b_0, g_b_1;
    logic [WIDTH-1:0] g_c_0 = '0;
    logic [WIDTH-1:0] g_c_1 = '0;
    logic             g_rand_ref, g_rand_mul;

    hpc3_mul_scheduler #(.WIDTH(WIDTH), .LATENCY(LATENCY), .SEED(SEED)) dut (
        .clk        (clk),
        .reset      (reset),
        .rq_bus     (bus),
        .g_a_0      (g_a_0),
        .g_a_1      (g_a_1),
        .g_b_0      (g_b_0),
        .g_b_1      (g_b_1),
        .g_rand_ref (g_rand_ref),
        .g_rand_mul (g_rand_mul),
        .g_c_0      (g_c_0),
        .g_c_1      (g_c_1)
    );

    // Behavioural one-stage gadget: c_0 ^ c_1 == (a_0^a_1) & (b_0^b_1).
    always @(posedge clk) begin
        g_c_0 <= (g_a_0 & g_b_0) ^ (g_a_0 & g_b_1) ^ {WIDTH{g_rand_mul}} ^ {WIDTH{g_rand_ref}};
        g_c_1 <= (g_a_1 & g_b_1) ^ (g_a_1 & g_b_0) ^ {WIDTH{g_rand_mul}} ^ {WIDTH{g_rand_ref}};
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    logic [WIDTH-1:0] exp_q0[$];
    logic [WIDTH-1:0] exp_q1[$];
    logic [1:0]       last_acc;

    // Stimulus side: one clock per call; queues the product of every accepted pair.
    task automatic step();
        logic [WIDTH-1:0] prod;
        @(negedge clk);
        last_acc = '0;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.rq_valid[i] && bus.rq_ready[i]) begin
                    last_acc[i] = 1'b1;
                    prod = (bus.rq_a_0[i] ^ bus.rq_a_1[i]) & (bus.rq_b_0[i] ^ bus.rq_b_1[i]);
                    if (i == 0) exp_q0.push_back(prod);
                    else        exp_q1.push_back(prod);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 2; i++) begin
            bus.rq_a_0[i] = WIDTH'($urandom);
            bus.rq_a_1[i] = WIDTH'($urandom);
            bus.rq_b_0[i] = WIDTH'($urandom);
            bus.rq_b_1[i] = WIDTH'($urandom);
        end
    endtask

    // Reference model state: outstanding flags, result due cycles, tie-break owner.
    logic [15:0]      m_lfsr = SEED;
    logic             m_rr   = 1'b0;
    logic [1:0]       m_busy = '0;
    int               m_due[2];
    int               cyc    = 0;
    logic [WIDTH-1:0] held0[2];
    logic [WIDTH-1:0] held1[2];
    logic [1:0]       held_v = '0;
    logic             after_reset = 1'b0;

    always @(negedge clk) begin
        logic [1:0]       elig, exp_gnt, exp_rsv, hs;
        logic [WIDTH-1:0] want;
        int               g;
        if (reset) begin
            check("rq_ready_in_reset", 32'(bus.rq_ready), 32'd0);
            m_lfsr = SEED;
            m_rr   = 1'b0;
            m_busy = '0;
            held_v = '0;
            exp_q0.delete();
            exp_q1.delete();
            after_reset = 1'b1;
        end else begin
            if (after_reset) begin
                check("rs_c_0_after_reset", 32'(bus.rs_c_0), 32'd0);
                check("rs_c_1_after_reset", 32'(bus.rs_c_1), 32'd0);
                after_reset = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                exp_rsv[i] = m_busy[i] && (cyc >= m_due[i]);
                check($sformatf("rs_valid[%0d]", i), 32'(bus.rs_valid[i]), 32'(exp_rsv[i]));
            end
            hs = exp_rsv & bus.rs_ready;
            for (int i = 0; i < 2; i++) begin
                if (exp_rsv[i]) begin
                    if (held_v[i]) begin
                        check($sformatf("rs_c_0_hold[%0d]", i), 32'(bus.rs_c_0[i]), 32'(held0[i]));
                        check($sformatf("rs_c_1_hold[%0d]", i), 32'(bus.rs_c_1[i]), 32'(held1[i]));
                    end
                    held0[i]  = bus.rs_c_0[i];
                    held1[i]  = bus.rs_c_1[i];
                    held_v[i] = !hs[i];
                end
                if (hs[i]) begin
                    if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                        check($sformatf("rs_unexpected_result[%0d]", i), 32'd1, 32'd0);
                    end else begin
                        want = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("rs_product[%0d]", i),
                              32'(bus.rs_c_0[i] ^ bus.rs_c_1[i]), 32'(want));
                    end
                    m_busy[i] = 1'b0;
                end
            end
            elig    = bus.rq_valid & ~(m_busy | hs);
            // A result taken this cycle does not make its requester eligible until next cycle.
            elig    = bus.rq_valid & ~((m_busy | hs) & ~hs | hs);
            exp_gnt = (elig == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : elig;
            check("rq_ready", 32'(bus.rq_ready), 32'(exp_gnt));
            if (exp_gnt != 2'b00) begin
                g = exp_gnt[1] ? 1 : 0;
                check("g_a_0", 32'(g_a_0), 32'(bus.rq_a_0[g]));
                check("g_a_1", 32'(g_a_1), 32'(bus.rq_a_1[g]));
                check("g_b_0", 32'(g_b_0), 32'(bus.rq_b_0[g]));
                check("g_b_1", 32'(g_b_1), 32'(bus.rq_b_1[g]));
                check("g_rand_mul", 32'(g_rand_mul), 32'(m_lfsr[0]));
                check("g_rand_ref", 32'(g_rand_ref), 32'(m_lfsr[8]));
                m_lfsr    = lfsr_next(m_lfsr);
                m_rr      = (g == 0);
                m_busy[g] = 1'b1;
                m_due[g]  = cyc + LATENCY + 1;
            end else begin
                check("g_shares_idle", 32'({g_a_0, g_a_1, g_b_0, g_b_1}), 32'd0);
                check("g_rand_idle", 32'({g_rand_ref, g_rand_mul}), 32'({m_lfsr[8], m_lfsr[0]}));
            end
        end
        cyc++;
    end

    initial begin
        logic [WIDTH-1:0] m, n;
        bit got;
        bus.rq_valid = '0;
        bus.rs_ready = '0;
        bus.rq_a_0 = '0; bus.rq_a_1 = '0; bus.rq_b_0 = '0; bus.rq_b_1 = '0;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        // Single op: a=101, b=011 behind random masks; result held while not taken.
        m = WIDTH'($urandom);
        n = WIDTH'($urandom);
        bus.rq_a_0[0] = m; bus.rq_a_1[0] = 3'b101 ^ m;
        bus.rq_b_0[0] = n; bus.rq_b_1[0] = 3'b011 ^ n;
        bus.rq_valid = 2'b01;
        step();
        bus.rq_valid = 2'b00;
        repeat (5) step();
        bus.rs_ready = 2'b11;
        repeat (3) step();

        // Both requesting continuously: strict alternation.
        bus.rq_valid = 2'b11;
        repeat (12) begin rand_ops(); step(); end

        // Requester 0 stalls its result; requester 1 keeps being served.
        bus.rs_ready = 2'b10;
        repeat (10) begin rand_ops(); step(); end
        bus.rs_ready = 2'b11;

        // Idle: shares zero, randomness frozen.
        bus.rq_valid = 2'b00;
        repeat (4) begin rand_ops(); step(); end

        // Random traffic and backpressure.
        repeat (400) begin
            rand_ops();
            bus.rq_valid = 2'($urandom);
            bus.rs_ready = 2'($urandom);
            step();
        end

        // Reset the cycle after an accept; the next op restarts the LFSR at SEED.
        bus.rq_valid = 2'b00;
        bus.rs_ready = 2'b11;
        repeat (5) step();
        rand_ops();
        bus.rq_valid = 2'b01;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            got = last_acc[0];
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        bus.rq_valid = 2'b00;
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (3) step();
        rand_ops();
        bus.rq_valid = 2'b01;
        step();
        bus.rq_valid = 2'b00;
        repeat (6) step();

        check("pending_results", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
